// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the input conditioner: debounce defaults
// and the counter-width calculation used by every channel.
package input_cond_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pin-side and CPU-side signal bundle of the input conditioner.
// The master side drives raw pins and clear strobes; the slave side is the conditioner.
interface input_conditioner_if #(
  parameter int WIDTH = 5
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] clr;

  modport master (
    output raw_in, clr,
    input  level, rise, fall, pressed
  );

  modport slave (
    input  raw_in, clr,
    output level, rise, fall, pressed
  );

endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One input channel: two-flop synchroniser, debounce counter, clean level and
// registered single-cycle rise/fall pulses.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw_in;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // Any return to the current level restarts the count, so bounces never pass.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        level <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Top of the input conditioner: WIDTH independent debounce channels plus the
// optional sticky pressed latch, built only when INPUT_COND_PRESS_LATCH_EN is defined.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic                clk,
  input logic                rst_n,
  input_conditioner_if.slave bus
);

  logic [WIDTH-1:0] level_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_in(bus.raw_in[i]),
      .level (level_v[i]),
      .rise  (rise_v[i]),
      .fall  (fall_v[i])
    );
  end

  assign bus.level = level_v;
  assign bus.rise  = rise_v;
  assign bus.fall  = fall_v;

`ifdef INPUT_COND_PRESS_LATCH_EN
  logic [WIDTH-1:0] pressed_q;

  // Set has priority over clear so a press arriving with a clear is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_q <= '0;
    end else begin
      pressed_q <= rise_v | (pressed_q & ~bus.clr);
    end
  end

  assign bus.pressed = pressed_q;
`else
  logic unused_clr;
  assign unused_clr  = ^bus.clr;
  assign bus.pressed = '0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed testbench for input_conditioner with DEBOUNCE_CYCLES=4, WIDTH=5.
// Expected values are hand-derived from the 6-cycle raw-to-level latency.
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int W = 5;
  localparam int D = DEBOUNCE_CYCLES_SIM;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  input_conditioner_if #(.WIDTH(W)) bus ();

  input_conditioner #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just past the next rising edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] exp_pressed(input logic [W-1:0] v);
`ifdef INPUT_COND_PRESS_LATCH_EN
    return v;
`else
    return '0;
`endif
  endfunction

  initial begin
    rst_n      = 1'b0;
    bus.raw_in = '1;
    bus.clr    = '0;

    // 1: reset hold with pins high, then release
    tick(3);
    check("rst_level",   32'(bus.level),   32'h0);
    check("rst_rise",    32'(bus.rise),    32'h0);
    check("rst_fall",    32'(bus.fall),    32'h0);
    check("rst_pressed", 32'(bus.pressed), 32'h0);
    rst_n = 1'b1;
    tick(5);
    check("t1_level_pre", 32'(bus.level), 32'h00);
    tick(1);
    check("t1_level",     32'(bus.level), 32'h1f);
    check("t1_rise",      32'(bus.rise),  32'h1f);
    tick(1);
    check("t1_rise_off",  32'(bus.rise),    32'h00);
    check("t1_level_hold",32'(bus.level),   32'h1f);
    check("t1_pressed",   32'(bus.pressed), 32'(exp_pressed(5'h1f)));

    // Clean restart with all pins low
    bus.raw_in = '0;
    rst_n      = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(8);
    check("t2_idle_level", 32'(bus.level), 32'h0);

    // 2: step channel 0 up, then down
    bus.raw_in[0] = 1'b1;
    tick(5);
    check("t2_up_pre",   32'(bus.level), 32'h00);
    tick(1);
    check("t2_up_level", 32'(bus.level), 32'h01);
    check("t2_up_rise",  32'(bus.rise),  32'h01);
    check("t2_up_fall",  32'(bus.fall),  32'h00);
    tick(1);
    check("t2_up_rise_off", 32'(bus.rise), 32'h00);
    bus.raw_in[0] = 1'b0;
    tick(5);
    check("t2_dn_pre",   32'(bus.level), 32'h01);
    tick(1);
    check("t2_dn_level", 32'(bus.level), 32'h00);
    check("t2_dn_fall",  32'(bus.fall),  32'h01);
    check("t2_dn_rise",  32'(bus.rise),  32'h00);
    tick(1);
    check("t2_dn_fall_off", 32'(bus.fall), 32'h00);

    // 3: short pulse and bounce on channel 1 must never pass
    begin
      logic [11:0] pat;
      pat = 12'b0000_1010_1110; // applied LSB first: 0,1,1,1,0,1,0,1,0,0,0,0
      for (int k = 0; k < 12; k++) begin
        bus.raw_in[1] = pat[k];
        tick(1);
        check("t3_level", 32'(bus.level[1]), 32'h0);
        check("t3_rise",  32'(bus.rise[1]),  32'h0);
        check("t3_fall",  32'(bus.fall[1]),  32'h0);
      end
      tick(6);
      check("t3_settled", 32'(bus.level), 32'h00);
    end

    // 4: pattern 1,0,1,1,... on channel 2; latency counts from last rise
    bus.raw_in[2] = 1'b1;
    tick(1);
    bus.raw_in[2] = 1'b0;
    tick(1);
    bus.raw_in[2] = 1'b1;
    tick(5);
    check("t4_pre",   32'(bus.level[2]), 32'h0);
    tick(1);
    check("t4_level", 32'(bus.level[2]), 32'h1);
    check("t4_rise",  32'(bus.rise[2]),  32'h1);

    // 5: pressed latch on channel 3
    bus.raw_in[3] = 1'b1;
    tick(6);
    check("t5_rise", 32'(bus.rise[3]), 32'h1);
    check("t5_pressed_pre", 32'(bus.pressed[3]), 32'h0);
    tick(1);
    check("t5_pressed_set", 32'(bus.pressed[3]), 32'(exp_pressed(5'h1f) & 5'h1));
    bus.clr[3] = 1'b1;
    tick(1);
    bus.clr[3] = 1'b0;
    check("t5_pressed_clr", 32'(bus.pressed[3]), 32'h0);
    bus.clr[3] = 1'b1;
    tick(1);
    bus.clr[3] = 1'b0;
    check("t5_clr_idle", 32'(bus.pressed[3]), 32'h0);
    bus.raw_in[3] = 1'b0;
    tick(7);
    check("t5_fell", 32'(bus.level[3]), 32'h0);
    bus.raw_in[3] = 1'b1;
    tick(6);
    check("t5_rise2", 32'(bus.rise[3]), 32'h1);
    bus.clr[3] = 1'b1;
    tick(1);
    bus.clr[3] = 1'b0;
    check("t5_set_wins", 32'(bus.pressed[3]), 32'(exp_pressed(5'h1f) & 5'h1));
    tick(1);
    check("t5_hold", 32'(bus.pressed[3]), 32'(exp_pressed(5'h1f) & 5'h1));

    // 6: asynchronous reset mid-count on channel 4
    bus.raw_in[4] = 1'b1;
    tick(4);
    check("t6_pre_level", 32'(bus.level), 32'h0c);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_level",   32'(bus.level),   32'h0);
    check("t6_async_pressed", 32'(bus.pressed), 32'h0);
    rst_n = 1'b1;
    tick(5);
    check("t6_restart_pre",  32'(bus.level), 32'h00);
    tick(1);
    check("t6_restart_level", 32'(bus.level), 32'h1c);
    check("t6_restart_rise",  32'(bus.rise),  32'h1c);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
